// File: rtl/ppi_port_a_strobe_receiver.sv
// 8255 Port A mode-1 strobed-output receiver. Answers /OBFA with a timed
// /ACKA pulse and queues each captured byte in a show-ahead FIFO.
module ppi_port_a_strobe_receiver #(
    parameter int FIFO_DEPTH = 8,
    parameter int ACK_DELAY  = 1,
    parameter int ACK_WIDTH  = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [7:0]                  port_a_data,
    input  logic                        port_a_io,
    input  logic                        obf_n,
    output logic                        ack_n,
    input  logic                        fifo_read,
    output logic [7:0]                  fifo_data,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 byte_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] DLY_LOAD = CW'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
    localparam logic [CW-1:0] WID_LOAD = CW'(ACK_WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACK,
        WAIT_HIGH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            ack_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            empty_q;
    logic            full_q;
    logic [15:0]     byte_count_q;
    logic            start;
    logic            push;
    logic            pop;

    // The push happens on the edge that enters ACK, so it is the only writer.
    always_comb begin
        start = (state_q == IDLE) && !obf_n && enable && !port_a_io && !full_q;
        push  = (start && (ACK_DELAY == 0)) || ((state_q == DELAY) && (cnt_q == '0));
        pop   = fifo_read && !empty_q;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (ACK_DELAY == 0) begin
                            state_q <= ACK;
                            ack_q   <= 1'b0;
                            cnt_q   <= WID_LOAD;
                        end else begin
                            state_q <= DELAY;
                            cnt_q   <= DLY_LOAD;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        state_q <= ACK;
                        ack_q   <= 1'b0;
                        cnt_q   <= WID_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ACK: begin
                    if (cnt_q == '0) begin
                        state_q <= WAIT_HIGH;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Hold here until /OBF releases so one strobe yields one byte.
                    if (obf_n) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q]  <= port_a_data;
                wr_q         <= wr_q + AW'(1);
                byte_count_q <= byte_count_q + 16'd1;
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
        end
    end

    assign ack_n      = ack_q;
    assign fifo_data  = mem_q[rd_q];
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign byte_count = byte_count_q;

endmodule
